seq_sub_16bit: RTL and testbench

SEQ_SUB_16BIT -- requirements
Module: seq_sub_16bit

---
 rtl/seq_sub_pkg.sv | 16 +
 rtl/cla_sub_4bit.sv | 32 +++
 rtl/seq_sub_16bit.sv | 102 ++++++++++
 tb/tb_seq_sub_16bit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_sub_pkg.sv
// Shared constants and FSM state encoding for the sequential nibble subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_sub_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 16;
    localparam int NIBBLES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_sub_4bit.sv
// 4-bit look-ahead subtractor slice: D = A - B - Bin, computed as A + ~B + ~Bin.
// Latency: purely combinational.
// Backpressure: none.
module cla_sub_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] D,
    output logic       Bout
);

    logic [3:0] b_inv;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign b_inv = ~B;
    assign p     = A ^ b_inv;
    assign g     = A & b_inv;

    // Carry-in is the inverted borrow; every carry is expanded from c[0] so no ripple chain remains.
    assign c[0] = ~Bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign D    = p ^ c[3:0];
    assign Bout = ~c[4];

endmodule

// File: rtl/seq_sub_16bit.sv
// Sequential 16-bit subtractor, one nibble per cycle through a shared slice; SEQ_SUB_SATURATE_EN floors negative results to 0.
// Latency: Done rises 5 edges after the accepting Start edge; next operands may be accepted in DONE (5-cycle throughput).
// Backpressure: Start is ignored while Busy; Diff/Bout hold the previous result until the new one completes.
module seq_sub_16bit
    import seq_sub_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              Start,
    output logic [WORD_W-1:0] Diff,
    output logic              Bout,
    output logic              Busy,
    output logic              Done
);

    localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

    state_t               state_q;
    logic [1:0]           idx_q;
    logic                 borrow_q;
    logic [WORD_W-1:0]    a_q;
    logic [WORD_W-1:0]    b_q;
    logic [WORD_W-1:0]    res_q;

    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  d_nib;
    logic                 bout_nib;
    logic [WORD_W-1:0]    word_nxt;
    logic [WORD_W-1:0]    diff_load;

    // Operand nibble mux feeding the single shared slice.
    assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    cla_sub_4bit u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .Bin  (borrow_q),
        .D    (d_nib),
        .Bout (bout_nib)
    );

    // On the last nibble the top 4 bits come straight from the slice, the rest from earlier cycles.
    assign word_nxt = {d_nib, res_q[WORD_W-NIBBLE_W-1:0]};

    // Select the value Diff loads on completion: wrapped, or floored at zero on borrow.
    always_comb begin
        diff_load = word_nxt;
`ifdef SEQ_SUB_SATURATE_EN
        if (bout_nib) begin
            diff_load = '0;
        end
`endif
    end

    // FSM, operand latches, nibble sequencing and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            Diff     <= '0;
            Bout     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        a_q      <= A;
                        b_q      <= B;
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        state_q  <= CALC;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                CALC: begin
                    res_q[idx_q*NIBBLE_W +: NIBBLE_W] <= d_nib;
                    borrow_q <= bout_nib;
                    idx_q    <= idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        Diff    <= diff_load;
                        Bout    <= bout_nib;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // DONE always exits after one cycle, so Done is a single-cycle pulse.
    assign Busy = (state_q == CALC);
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_seq_sub_16bit.sv
// Directed bench for seq_sub_16bit: vector table plus hand-written corner sequences.
// Latency: checks Start-to-Done edge count and Busy duration per operation.
// Backpressure: exercises Start held during CALC and back-to-back Start in DONE.
module tb_seq_sub_16bit;

    logic        CLK;
    logic        RST_N;
    logic [15:0] A;
    logic [15:0] B;
    logic        Start;
    logic [15:0] Diff;
    logic        Bout;
    logic        Busy;
    logic        Done;

    int total_cnt = 0;
    int pass_cnt  = 0;

    seq_sub_16bit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .A     (A),
        .B     (B),
        .Start (Start),
        .Diff  (Diff),
        .Bout  (Bout),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        bout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) until Done is seen at a negedge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_n);
        @(negedge CLK);
        A = a; B = b; Start = 1'b1;
        @(posedge CLK);
        lat = 1; busy_n = 0;
        @(negedge CLK);
        Start = 1'b0;
        while (!Done && lat < 12) begin
            if (Busy) busy_n++;
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
    endtask

    initial begin
        int          lat;
        int          busy_n;
        logic [15:0] held;

        vecs[0] = '{"basic_1234_0034", 16'h1234, 16'h0034, 16'h1200, 1'b0};
        vecs[1] = '{"ripple_8000_0001", 16'h8000, 16'h0001, 16'h7FFF, 1'b0};
`ifdef SEQ_SUB_SATURATE_EN
        vecs[2] = '{"under_0000_0001", 16'h0000, 16'h0001, 16'h0000, 1'b1};
        vecs[3] = '{"under_00F0_0F00", 16'h00F0, 16'h0F00, 16'h0000, 1'b1};
`else
        vecs[2] = '{"under_0000_0001", 16'h0000, 16'h0001, 16'hFFFF, 1'b1};
        vecs[3] = '{"under_00F0_0F00", 16'h00F0, 16'h0F00, 16'hF1F0, 1'b1};
`endif
        vecs[4] = '{"mixed_ABCD_1234", 16'hABCD, 16'h1234, 16'h9999, 1'b0};
        vecs[5] = '{"equal_5A5A_5A5A", 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0};
        vecs[6] = '{"max_FFFF_0000", 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};

        RST_N = 1'b0; A = '0; B = '0; Start = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_diff", 32'(Diff), 32'h0);
        check("reset_bout", 32'(Bout), 32'h0);
        check("reset_busy", 32'(Busy), 32'h0);
        check("reset_done", 32'(Done), 32'h0);
        RST_N = 1'b1;

        // Table-driven operations, each returning to IDLE in between.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, busy_n);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'd5);
            check({vecs[i].name, "_busy"}, 32'(busy_n), 32'd4);
            check({vecs[i].name, "_diff"}, 32'(Diff), 32'(vecs[i].diff));
            check({vecs[i].name, "_bout"}, 32'(Bout), 32'(vecs[i].bout));
            @(negedge CLK);
            check({vecs[i].name, "_done_pulse"}, 32'(Done), 32'h0);
            check({vecs[i].name, "_hold"}, 32'(Diff), 32'(vecs[i].diff));
        end

        // Start held high with changing operands during CALC must be ignored.
        @(negedge CLK);
        A = 16'h0100; B = 16'h0001; Start = 1'b1;
        @(posedge CLK);
        lat = 1;
        @(negedge CLK);
        while (!Done && lat < 12) begin
            A = 16'hFFFF; B = 16'h0000; Start = 1'b1;
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        check("ignore_lat", 32'(lat), 32'd5);
        check("ignore_diff", 32'(Diff), 32'h00FF);
        check("ignore_bout", 32'(Bout), 32'h0);

        // Back-to-back: Start in DONE accepts new operands immediately.
        held = Diff;
        A = 16'h0005; B = 16'h0003; Start = 1'b1;
        @(posedge CLK);
        lat = 1;
        @(negedge CLK);
        Start = 1'b0;
        check("b2b_busy", 32'(Busy), 32'h1);
        check("b2b_hold_during_calc", 32'(Diff), 32'(held));
        while (!Done && lat < 12) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        check("b2b_lat", 32'(lat), 32'd5);
        check("b2b_diff", 32'(Diff), 32'h0002);
        check("b2b_bout", 32'(Bout), 32'h0);

        // Reset asserted during the second CALC cycle clears everything at once.
        @(negedge CLK);
        A = 16'h00FF; B = 16'h0001; Start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("mid_busy_before_reset", 32'(Busy), 32'h1);
        RST_N = 1'b0;
        #1;
        check("midrst_diff", 32'(Diff), 32'h0);
        check("midrst_bout", 32'(Bout), 32'h0);
        check("midrst_busy", 32'(Busy), 32'h0);
        check("midrst_done", 32'(Done), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("postrst_idle_busy", 32'(Busy), 32'h0);
        run_op(16'hFFFF, 16'hFFFF, lat, busy_n);
        check("postrst_lat", 32'(lat), 32'd5);
        check("postrst_busy", 32'(busy_n), 32'd4);
        check("postrst_diff", 32'(Diff), 32'h0);
        check("postrst_bout", 32'(Bout), 32'h0);
        check("postrst_done", 32'(Done), 32'h1);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
